instr_encoder: RTL and testbench

//  Packs decoded instruction fields (opcode, fn, regs, imm, jump target) into 16-bit MPU instruction words, inverse of decode.

---
 rtl/mpu_isa_pkg.sv | 30 +++
 rtl/enc_skid_buf.sv | 51 +++++
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_isa_pkg.sv
// rtl/mpu_isa_pkg.sv - MPU instruction-set constants shared by the encoder and decoder
package mpu_isa_pkg;

    localparam int OP_W    = 3;
    localparam int FN_W    = 2;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 8;
    localparam int IMMF_W  = 7;
    localparam int TGT_W   = 13;
    localparam int INSTR_W = 16;

    localparam logic [OP_W-1:0] OP_R       = 3'b000;
    localparam logic [OP_W-1:0] OP_I_FIRST = 3'b001;
    localparam logic [OP_W-1:0] OP_I_LAST  = 3'b100;
    localparam logic [OP_W-1:0] OP_J       = 3'b101;

    localparam logic signed [IMM_W-1:0] IMM_MAX = 8'sd63;
    localparam logic signed [IMM_W-1:0] IMM_MIN = -8'sd64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } enc_state_e;

    function automatic logic imm_out_of_range(input logic [IMM_W-1:0] imm);
        return ($signed(imm) > IMM_MAX) || ($signed(imm) < IMM_MIN);
    endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// rtl/enc_skid_buf.sv - 2-entry registered valid/ready buffer for packed words
module enc_skid_buf #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata_i,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign s_tready_o = (cnt_q != 2'd2);
    assign m_tvalid_o = (cnt_q != 2'd0);
    assign m_tdata_o  = mem_q[rd_ptr_q];
    assign push       = s_tvalid_i && s_tready_o;
    assign pop        = m_tvalid_o && m_tready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_tdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into 16-bit words for the loader; IMM_SAT_EN saturates bad immediates
module instr_encoder
    import mpu_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [OP_W-1:0]      in_opcode,
    input  logic [FN_W-1:0]      in_fn,
    input  logic [REG_W-1:0]     in_rd,
    input  logic [REG_W-1:0]     in_rs,
    input  logic [REG_W-1:0]     in_rt,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic [TGT_W-1:0]     in_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err_illegal,
    output logic                 err_range,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    enc_state_e            state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  err_illegal_q;
    logic                  err_range_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic                  done_q;

    logic                  op_illegal;
    logic                  op_itype;
    logic                  imm_oor;
    logic                  beat_drop;
    logic [IMMF_W-1:0]     imm_eff;
    logic [INSTR_W-1:0]    word;
    logic                  buf_ready;
    logic                  beat_acc;
    logic                  beat_emit;

    always_comb begin
        op_illegal = (in_opcode == 3'b110) || (in_opcode == 3'b111);
        op_itype   = (in_opcode >= OP_I_FIRST) && (in_opcode <= OP_I_LAST);
        imm_oor    = op_itype && imm_out_of_range(in_imm);
        imm_eff    = in_imm[IMMF_W-1:0];
`ifdef IMM_SAT_EN
        if (imm_oor) begin
            imm_eff = in_imm[IMM_W-1] ? IMM_MIN[IMMF_W-1:0] : IMM_MAX[IMMF_W-1:0];
        end
        beat_drop = op_illegal;
`else
        beat_drop = op_illegal || imm_oor;
`endif
        if (in_opcode == OP_R) begin
            word = {in_opcode, in_fn, 2'b00, in_rd, in_rs, in_rt};
        end else if (op_itype) begin
            word = {in_opcode, imm_eff, in_rs, in_rt};
        end else begin
            word = {in_opcode, in_target};
        end
    end

    assign in_ready  = (state_q == ST_RUN) && buf_ready;
    assign beat_acc  = in_valid && in_ready;
    assign beat_emit = beat_acc && !beat_drop;

    // A word landing on the top address closes the program: the address space never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            err_illegal_q <= 1'b0;
            err_range_q   <= 1'b0;
            err_cnt_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_RUN;
                        addr_q        <= base_addr;
                        err_illegal_q <= 1'b0;
                        err_range_q   <= 1'b0;
                        err_cnt_q     <= '0;
                    end
                end
                ST_RUN: begin
                    if (beat_emit && (addr_q != ADDR_MAX)) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    if (beat_acc && op_illegal) begin
                        err_illegal_q <= 1'b1;
                    end
                    if (beat_acc && imm_oor) begin
                        err_range_q <= 1'b1;
                    end
                    if (beat_acc && beat_drop && (err_cnt_q != '1)) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    if (beat_acc && (in_last || (beat_emit && (addr_q == ADDR_MAX)))) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    enc_skid_buf #(
        .WIDTH(INSTR_W + ADDR_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata_i  ({word, addr_q}),
        .s_tvalid_i (beat_emit),
        .s_tready_o (buf_ready),
        .m_tdata_o  ({out_instr, out_addr}),
        .m_tvalid_o (out_valid),
        .m_tready_i (out_ready)
    );

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err_illegal = err_illegal_q;
    assign err_range   = err_range_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (either IMM_SAT_EN build)
module tb_instr_encoder;

    localparam int ADDR_W    = 8;
    localparam int ERR_CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [ADDR_W-1:0]    base_addr = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_last = 1'b0;
    logic [2:0]           in_opcode = '0;
    logic [1:0]           in_fn = '0;
    logic [2:0]           in_rd = '0;
    logic [2:0]           in_rs = '0;
    logic [2:0]           in_rt = '0;
    logic [7:0]           in_imm = '0;
    logic [12:0]          in_target = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [15:0]          out_instr;
    logic [ADDR_W-1:0]    out_addr;
    logic                 busy;
    logic                 done;
    logic                 err_illegal;
    logic                 err_range;
    logic [ERR_CNT_W-1:0] err_cnt;

    instr_encoder #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_fn(in_fn), .in_rd(in_rd), .in_rs(in_rs),
        .in_rt(in_rt), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .busy(busy), .done(done), .err_illegal(err_illegal),
        .err_range(err_range), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          ready_seen = 0;
    logic [23:0] sb [$];
    logic [23:0] sb_exp;
    logic [7:0]  exp_addr = '0;
    logic        exp_ill = 1'b0;
    logic        exp_rng = 1'b0;
    int          exp_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check_val("word", {8'h0, out_instr, out_addr}, {8'h0, sb_exp});
            end
        end
    end

    task automatic start_prog(input logic [7:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = base;
        exp_ill = 1'b0;
        exp_rng = 1'b0;
        exp_cnt = 0;
        done_base = done_cnt;
    endtask

    task automatic model_beat(input logic [2:0] op, input logic [1:0] fn, input logic [2:0] rd,
                              input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm,
                              input logic [12:0] tgt);
        int         si;
        bit         ill, itp, oor, drop;
        logic [6:0] imf;
        logic [15:0] w;
        si  = $signed(imm);
        ill = (op >= 3'd6);
        itp = (op >= 3'd1) && (op <= 3'd4);
        oor = itp && ((si > 63) || (si < -64));
        imf = imm[6:0];
`ifdef IMM_SAT_EN
        if (oor) imf = (si < 0) ? 7'h40 : 7'h3F;
        drop = ill;
`else
        drop = ill || oor;
`endif
        if (ill) exp_ill = 1'b1;
        if (oor) exp_rng = 1'b1;
        if (drop && exp_cnt < 15) exp_cnt++;
        if (!drop) begin
            if (op == 3'd0) w = {op, fn, 2'b00, rd, rs, rt};
            else if (itp)   w = {op, imf, rs, rt};
            else            w = {op, tgt};
            sb.push_back({w, exp_addr});
            exp_addr = exp_addr + 8'd1;
        end
    endtask

    task automatic set_beat(input logic [2:0] op, input logic [1:0] fn, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm,
                            input logic [12:0] tgt, input logic last);
        in_valid = 1'b1;
        in_opcode = op; in_fn = fn; in_rd = rd; in_rs = rs; in_rt = rt;
        in_imm = imm; in_target = tgt; in_last = last;
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [1:0] fn, input logic [2:0] rd,
                             input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm,
                             input logic [12:0] tgt, input logic last);
        bit acc;
        acc = 1'b0;
        set_beat(op, fn, rd, rs, rt, imm, tgt, last);
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                model_beat(op, fn, rd, rs, rt, imm, tgt);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_errs();
        check_val("err_illegal", err_illegal, exp_ill);
        check_val("err_range", err_range, exp_rng);
        check_val("err_cnt", err_cnt, exp_cnt);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && done_cnt == done_base; i++) @(negedge clk);
        @(negedge clk);
        check_val("done_pulse", done_cnt - done_base, 32'd1);
        check_val("busy_idle", busy, 1'b0);
        check_val("sb_drained", sb.size(), 32'd0);
        check_errs();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_errs", {err_illegal, err_range, err_cnt}, 6'h0);
        check_val("rst_out", {out_instr, out_addr}, 24'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // R word then I and J, with a stray start mid-program
        start_prog(8'h10);
        start = 1'b1; base_addr = 8'h99;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(3'b000, 2'b10, 3'd3, 3'd1, 3'd2, 8'h00, 13'h0, 1'b0);
        @(negedge clk);
        check_val("lat_valid", out_valid, 1'b1);
        check_val("lat_word", {out_instr, out_addr}, {16'h10CA, 8'h10});
        @(posedge clk); #1;
        send_beat(3'b001, 2'b00, 3'd0, 3'd2, 3'd5, 8'hFD, 13'h0, 1'b0);
        send_beat(3'b101, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 13'h0123, 1'b1);
        wait_done();

        // illegal opcode mid-stream
        start_prog(8'h40);
        send_beat(3'b000, 2'b01, 3'd7, 3'd6, 3'd5, 8'h00, 13'h0, 1'b0);
        send_beat(3'b110, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 13'h0, 1'b0);
        send_beat(3'b011, 2'b00, 3'd0, 3'd4, 3'd1, 8'h05, 13'h0, 1'b1);
        wait_done();

        // immediate range boundaries; program ends on a possibly dropped beat
        start_prog(8'h50);
        send_beat(3'b010, 2'b00, 3'd0, 3'd1, 3'd2, 8'd63, 13'h0, 1'b0);
        send_beat(3'b100, 2'b00, 3'd0, 3'd3, 3'd4, 8'hC0, 13'h0, 1'b0);
        send_beat(3'b000, 2'b11, 3'd1, 3'd1, 3'd1, 8'd100, 13'h0, 1'b0);
        send_beat(3'b010, 2'b00, 3'd0, 3'd0, 3'd0, 8'd100, 13'h0, 1'b0);
        send_beat(3'b001, 2'b00, 3'd0, 3'd0, 3'd0, 8'd64, 13'h0, 1'b0);
        send_beat(3'b010, 2'b00, 3'd0, 3'd0, 3'd0, 8'h9C, 13'h0, 1'b1);
        wait_done();

        // err_cnt saturation
        start_prog(8'h80);
        for (int i = 0; i < 17; i++) send_beat(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 13'h0, 1'b0);
        send_beat(3'b000, 2'b00, 3'd2, 3'd2, 3'd2, 8'h00, 13'h0, 1'b1);
        wait_done();

        // back-pressure: two words buffered, then in_ready stays low
        start_prog(8'h60);
        out_ready = 1'b0;
        send_beat(3'b000, 2'b01, 3'd1, 3'd2, 3'd3, 8'h00, 13'h0, 1'b0);
        send_beat(3'b101, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 13'h1ABC, 1'b0);
        set_beat(3'b011, 2'b00, 3'd0, 3'd7, 3'd6, 8'h11, 13'h0, 1'b0);
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) ready_seen++;
            @(posedge clk); #1;
        end
        check_val("bp_in_ready", ready_seen, 32'd0);
        @(negedge clk);
        check_val("bp_hold", {out_valid, out_instr, out_addr}, {1'b1, sb[0]});
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(3'b011, 2'b00, 3'd0, 3'd7, 3'd6, 8'h11, 13'h0, 1'b0);
        send_beat(3'b000, 2'b00, 3'd4, 3'd5, 3'd6, 8'h00, 13'h0, 1'b1);
        wait_done();

        // top of address space: only 0xFE and 0xFF written
        start_prog(8'hFE);
        send_beat(3'b000, 2'b00, 3'd1, 3'd0, 3'd0, 8'h00, 13'h0, 1'b0);
        send_beat(3'b000, 2'b00, 3'd2, 3'd0, 3'd0, 8'h00, 13'h0, 1'b0);
        set_beat(3'b000, 2'b00, 3'd3, 3'd0, 3'd0, 8'h00, 13'h0, 1'b0);
        ready_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready) ready_seen++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("max_in_ready", ready_seen, 32'd0);
        wait_done();

        // reset mid-program
        start_prog(8'h20);
        out_ready = 1'b0;
        send_beat(3'b000, 2'b00, 3'd1, 3'd1, 3'd1, 8'h00, 13'h0, 1'b0);
        send_beat(3'b000, 2'b00, 3'd2, 3'd2, 3'd2, 8'h00, 13'h0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        done_base = done_cnt;
        repeat (4) @(negedge clk);
        check_val("mid_rst_state", {out_valid, busy, in_ready}, 3'b000);
        check_val("mid_rst_no_done", done_cnt - done_base, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        start_prog(8'h00);
        send_beat(3'b101, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 13'h1FFF, 1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
